// File: rtl/chs_ramp_controller.sv
// -----------------------------------------------------------------------------
// chs_ramp_controller
//
// Sequential controller for the cooling/heating system (CHS) actuator. It
// captures the power/mode request from the temperature-to-power mapper and
// drives the actuator:
//   - power is slew-limited to one step per tick (a tick is every STEP_DIV
//     clock cycles);
//   - a mode reversal first drains power to zero, then holds zero power for
//     DEAD_CYCLES cycles, and only then switches the mode.
//
// Optional feature: define CHS_OVERTEMP_EN to add the over-temperature fault.
// At temp >= OT_LIMIT, power drops to zero and the controller parks in FAULT.
// It leaves FAULT through the dead time on fault_clr while temp < OT_LIMIT.
// Without the macro, ot_fault is tied low and temp/fault_clr are ignored.
//
// Parameters:
//   STEP_DIV     clock cycles per power step (>= 1)
//   DEAD_CYCLES  cycles at zero power before a mode switch (>= 1)
//   OT_LIMIT     over-temperature threshold (only used with CHS_OVERTEMP_EN)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   capture req_power/req_mode on this edge
//   req_power  in   requested power 0..31
//   req_mode   in   requested mode (mapper chs_mode encoding)
//   temp       in   current temperature code
//   fault_clr  in   clear the over-temperature fault
//   chs_power  out  applied actuator power (registered)
//   chs_mode   out  applied actuator mode (registered)
//   busy       out  high whenever the controller is not in HOLD
//   ot_fault   out  over-temperature fault latched
// -----------------------------------------------------------------------------
module chs_ramp_controller #(
   parameter int unsigned STEP_DIV    = 4,
   parameter int unsigned DEAD_CYCLES = 8,
   parameter logic [7:0]  OT_LIMIT    = 8'd250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [4:0] req_power,
   input  logic       req_mode,
   input  logic [7:0] temp,
   input  logic       fault_clr,
   output logic [4:0] chs_power,
   output logic       chs_mode,
   output logic       busy,
   output logic       ot_fault
);

   localparam int unsigned SW = (STEP_DIV    > 1) ? $clog2(STEP_DIV)    : 1;
   localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_HOLD  = 3'd0,
      ST_RAMP  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DEAD  = 3'd3
`ifdef CHS_OVERTEMP_EN
      ,
      ST_FAULT = 3'd4
`endif
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [4:0]    tgt_power;
   logic          tgt_mode;
   logic [SW-1:0] step_cnt;
   logic [SW-1:0] step_nxt;
   logic [DW-1:0] dead_cnt;
   logic [DW-1:0] dead_nxt;
   logic [4:0]    power_nxt;
   logic          mode_nxt;
   logic          tick;

`ifdef CHS_OVERTEMP_EN
   logic over_temp;
   assign over_temp = (temp >= OT_LIMIT);
`else
   // The fault inputs have no function in this build.
   logic unused_ot_inputs;
   assign unused_ot_inputs = ^{temp, fault_clr, OT_LIMIT};
   assign ot_fault = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // State register and datapath registers
   // --------------------------------------------------------------------------
   // NOTE: all state is written with <= so every register samples the
   // pre-edge values that the next-state logic computed from.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_HOLD;
         tgt_power <= '0;
         tgt_mode  <= 1'b0;
         chs_power <= '0;
         chs_mode  <= 1'b0;
         step_cnt  <= '0;
         dead_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         chs_power <= power_nxt;
         chs_mode  <= mode_nxt;
         step_cnt  <= step_nxt;
         dead_cnt  <= dead_nxt;
         // The target always loads. A step on this same edge has already
         // been computed from the old target.
         if (req_valid) begin
            tgt_power <= req_power;
            tgt_mode  <= req_mode;
         end
      end
   end

`ifdef CHS_OVERTEMP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ot_fault <= 1'b0;
      end else if (over_temp) begin
         ot_fault <= 1'b1;
      end else if (state == ST_FAULT && state_nxt == ST_DEAD) begin
         ot_fault <= 1'b0;
      end
   end
`endif

   // --------------------------------------------------------------------------
   // Next-state and datapath logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case statement, so no
      // path through the block can leave a latch behind.
      state_nxt = state;
      power_nxt = chs_power;
      mode_nxt  = chs_mode;
      step_nxt  = '0;
      dead_nxt  = '0;
      tick      = (step_cnt == STEP_LAST);

      case (state)
         ST_HOLD: begin
            if (tgt_mode != chs_mode) begin
               state_nxt = (chs_power != 5'd0) ? ST_DRAIN : ST_DEAD;
            end else if (chs_power != tgt_power) begin
               state_nxt = ST_RAMP;
            end
         end

         ST_RAMP: begin
            step_nxt = tick ? '0 : step_cnt + SW'(1);
            if (tgt_mode != chs_mode) begin
               // A mode reversal aborts the ramp without waiting for a tick.
               state_nxt = (chs_power != 5'd0) ? ST_DRAIN : ST_DEAD;
            end else if (chs_power == tgt_power) begin
               // A retarget landed exactly on the current power.
               state_nxt = ST_HOLD;
            end else if (tick) begin
               // Direction follows whatever the target is on this tick.
               power_nxt = (chs_power < tgt_power) ? chs_power + 5'd1
                                                   : chs_power - 5'd1;
               if (power_nxt == tgt_power) begin
                  state_nxt = ST_HOLD;
               end
            end
         end

         ST_DRAIN: begin
            step_nxt = tick ? '0 : step_cnt + SW'(1);
            if (chs_power == 5'd0) begin
               state_nxt = ST_DEAD;
            end else if (tick) begin
               power_nxt = chs_power - 5'd1;
               if (chs_power == 5'd1) begin
                  state_nxt = ST_DEAD;
               end
            end
         end

         ST_DEAD: begin
            // The dead time always runs to completion. The mode is picked up
            // from the target only on its last cycle.
            if (dead_cnt == DEAD_LAST) begin
               mode_nxt  = tgt_mode;
               state_nxt = (tgt_power != 5'd0) ? ST_RAMP : ST_HOLD;
            end else begin
               dead_nxt = dead_cnt + DW'(1);
            end
         end

`ifdef CHS_OVERTEMP_EN
         ST_FAULT: begin
            power_nxt = '0;
            if (fault_clr && !over_temp) begin
               state_nxt = ST_DEAD;
            end
         end
`endif

         default: begin
            state_nxt = ST_HOLD;
         end
      endcase

`ifdef CHS_OVERTEMP_EN
      // Over-temperature overrides every state.
      if (over_temp) begin
         state_nxt = ST_FAULT;
         power_nxt = '0;
      end
`endif

      // Both counters restart on every state change.
      if (state_nxt != state) begin
         step_nxt = '0;
         dead_nxt = '0;
      end
   end

   // --------------------------------------------------------------------------
   // Output logic
   // --------------------------------------------------------------------------
   always_comb begin
      busy = (state != ST_HOLD);
   end

endmodule

// File: tb/tb_chs_ramp_controller.sv
`timescale 1ns/1ps
module tb_chs_ramp_controller;

   localparam int STEP_DIV    = 4;
   localparam int DEAD_CYCLES = 8;

`ifdef CHS_OVERTEMP_EN
   localparam bit OT_ON = 1'b1;
`else
   localparam bit OT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [4:0] req_power = '0;
   logic       req_mode = 1'b0;
   logic [7:0] temp = 8'd20;
   logic       fault_clr = 1'b0;
   logic [4:0] chs_power;
   logic       chs_mode;
   logic       busy;
   logic       ot_fault;

   chs_ramp_controller #(
      .STEP_DIV   (STEP_DIV),
      .DEAD_CYCLES(DEAD_CYCLES),
      .OT_LIMIT   (8'd250)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_power(req_power),
      .req_mode (req_mode),
      .temp     (temp),
      .fault_clr(fault_clr),
      .chs_power(chs_power),
      .chs_mode (chs_mode),
      .busy     (busy),
      .ot_fault (ot_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] power;
      logic       mode;
      logic       busy;
      logic       ot;
   } obs_t;

   typedef struct {
      int         at;
      logic       rst;
      logic       valid;
      logic [4:0] pwr;
      logic       mode;
      logic [7:0] temp;
      logic       clr;
      logic       chk;
      obs_t       exp;
      string      name;
   } vec_t;

   vec_t  tbl[$];
   obs_t  exp_q[$];
   string name_q[$];
   int    n_vec = 0;
   int    n_bad = 0;
   int    ecnt  = 0;

   function automatic obs_t mk(input logic [4:0] p, input logic m,
                               input logic b, input logic o);
      obs_t r;
      r.power = p;
      r.mode  = m;
      r.busy  = b;
      r.ot    = o;
      return r;
   endfunction

   function automatic void add(input int at, input logic r, input logic v,
                               input logic [4:0] p, input logic m,
                               input logic chk, input obs_t e, input string nm);
      vec_t t;
      t.at    = at;
      t.rst   = r;
      t.valid = v;
      t.pwr   = p;
      t.mode  = m;
      t.temp  = 8'd20;
      t.clr   = 1'b0;
      t.chk   = chk;
      t.exp   = e;
      t.name  = nm;
      tbl.push_back(t);
   endfunction

   task automatic check(input string nm, input obs_t e);
      obs_t got;
      got = {chs_power, chs_mode, busy, ot_fault};
      n_vec++;
      if (got !== e) begin
         n_bad++;
         $display("FAIL %s: got power=%0d mode=%0d busy=%0d ot=%0d, expected power=%0d mode=%0d busy=%0d ot=%0d",
                  nm, got.power, got.mode, got.busy, got.ot,
                  e.power, e.mode, e.busy, e.ot);
      end
   endtask

   // Drive one edge. The expected result is queued with the stimulus and
   // retired once the DUT has registered that edge.
   task automatic apply(input logic r, input logic v, input logic [4:0] p,
                        input logic m, input logic [7:0] t, input logic c,
                        input logic chk, input obs_t e, input string nm);
      rst       = r;
      req_valid = v;
      req_power = p;
      req_mode  = m;
      temp      = t;
      fault_clr = c;
      if (chk) begin
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
      @(posedge clk);
      ecnt++;
      #1;
      if (chk) check(name_q.pop_front(), exp_q.pop_front());
   endtask

   task automatic idle(input int n);
      logic [4:0] junk_p;
      logic       junk_m;
      for (int k = 0; k < n; k++) begin
         junk_p = 5'($urandom);
         junk_m = 1'($urandom);
         apply(1'b0, 1'b0, junk_p, junk_m, 8'd20, 1'b0, 1'b0, '0, "");
      end
   endtask

   task automatic idle_chk(input obs_t e, input string nm);
      apply(1'b0, 1'b0, 5'd0, 1'b0, 8'd20, 1'b0, 1'b1, e, nm);
   endtask

   task automatic wait_power(input logic [4:0] p, input int budget,
                             input string nm);
      int k;
      k = 0;
      while (chs_power !== p && k < budget) begin
         idle(1);
         k++;
      end
      n_vec++;
      if (chs_power !== p) begin
         n_bad++;
         $display("FAIL %s: timeout after %0d cycles, power=%0d expected %0d",
                  nm, budget, chs_power, p);
      end
   endtask

   initial begin
      int b;
      int f;

      // ---------------- timed vector table (edge numbers from 1) ----------
      add(1, 1, 0, 0, 0, 1, mk(0, 0, 0, 0), "reset_edge1");
      add(2, 1, 0, 0, 0, 1, mk(0, 0, 0, 0), "reset_edge2");

      // Ramp up 0 -> 3, mode 0.
      b = 3;
      add(b,      0, 1, 3, 0, 1, mk(0, 0, 0, 0), "ramp_req_edge");
      add(b + 1,  0, 0, 0, 0, 1, mk(0, 0, 1, 0), "ramp_leave_hold");
      add(b + 4,  0, 0, 0, 0, 1, mk(0, 0, 1, 0), "ramp_before_step1");
      add(b + 5,  0, 0, 0, 0, 1, mk(1, 0, 1, 0), "ramp_step1");
      add(b + 9,  0, 0, 0, 0, 1, mk(2, 0, 1, 0), "ramp_step2");
      add(b + 12, 0, 0, 0, 0, 1, mk(2, 0, 1, 0), "ramp_before_step3");
      add(b + 13, 0, 0, 0, 0, 1, mk(3, 0, 0, 0), "ramp_done_hold");

      // Mode reversal 3/0 -> 2/1.
      b = b + 15;
      add(b,      0, 1, 2, 1, 0, mk(0, 0, 0, 0), "");
      add(b + 5,  0, 0, 0, 0, 1, mk(2, 0, 1, 0), "rev_drain1");
      add(b + 9,  0, 0, 0, 0, 1, mk(1, 0, 1, 0), "rev_drain2");
      add(b + 13, 0, 0, 0, 0, 1, mk(0, 0, 1, 0), "rev_drained");
      add(b + 20, 0, 0, 0, 0, 1, mk(0, 0, 1, 0), "rev_dead_last");
      add(b + 21, 0, 0, 0, 0, 1, mk(0, 1, 1, 0), "rev_mode_switch");
      add(b + 25, 0, 0, 0, 0, 1, mk(1, 1, 1, 0), "rev_ramp1");
      add(b + 28, 0, 0, 0, 0, 1, mk(1, 1, 1, 0), "rev_before_ramp2");
      add(b + 29, 0, 0, 0, 0, 1, mk(2, 1, 0, 0), "rev_hold");

      // Reverse back to 0/0: drain, dead time, hold at zero.
      b = b + 31;
      add(b,      0, 1, 0, 0, 0, mk(0, 0, 0, 0), "");
      add(b + 9,  0, 0, 0, 0, 1, mk(0, 1, 1, 0), "drain_zero_dead");
      add(b + 17, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "drain_zero_hold");

      // Zero-power mode change 0/0 -> 0/1.
      b = b + 19;
      add(b,      0, 1, 0, 1, 1, mk(0, 0, 0, 0), "zp_req");
      add(b + 1,  0, 0, 0, 0, 1, mk(0, 0, 1, 0), "zp_dead");
      add(b + 8,  0, 0, 0, 0, 1, mk(0, 0, 1, 0), "zp_dead_last");
      add(b + 9,  0, 0, 0, 0, 1, mk(0, 1, 0, 0), "zp_mode_switch");

      b = b + 11;
      add(b,      0, 1, 0, 0, 0, mk(0, 0, 0, 0), "");
      add(b + 9,  0, 0, 0, 0, 1, mk(0, 0, 0, 0), "zp_back");

      // Request landing on a tick edge: that step still uses the old target.
      b = b + 11;
      add(b,      0, 1, 5, 0, 0, mk(0, 0, 0, 0), "");
      add(b + 13, 0, 1, 1, 0, 1, mk(3, 0, 1, 0), "tick_uses_old_target");
      add(b + 17, 0, 0, 0, 0, 1, mk(2, 0, 1, 0), "tick_new_target_down");
      add(b + 21, 0, 0, 0, 0, 1, mk(1, 0, 0, 0), "tick_new_target_hold");

      for (int i = 0; i < tbl.size(); i++) begin
         while (ecnt + 1 < tbl[i].at) idle(1);
         apply(tbl[i].rst, tbl[i].valid, tbl[i].pwr, tbl[i].mode,
               tbl[i].temp, tbl[i].clr, tbl[i].chk, tbl[i].exp, tbl[i].name);
      end

      // ---------------- reset mid-RAMP -------------------------------------
      apply(0, 1, 5'd20, 0, 8'd20, 0, 0, '0, "");
      idle(5);
      idle_chk(mk(2, 0, 1, 0), "rstmid_ramping");
      apply(1, 0, 5'd0, 0, 8'd20, 0, 1, mk(0, 0, 0, 0), "rst_first_edge");
      apply(1, 0, 5'd0, 0, 8'd20, 0, 1, mk(0, 0, 0, 0), "rst_second_edge");
      idle(4);
      idle_chk(mk(0, 0, 0, 0), "post_rst_target_cleared");

      // ---------------- retarget mid-ramp ---------------------------------
      apply(0, 1, 5'd10, 0, 8'd20, 0, 0, '0, "");
      wait_power(5'd4, 40, "retarget_reach4");
      apply(0, 1, 5'd2, 0, 8'd20, 0, 1, mk(4, 0, 1, 0), "retarget_edge");
      idle(2);
      idle_chk(mk(3, 0, 1, 0), "retarget_step_down");
      idle(3);
      idle_chk(mk(2, 0, 0, 0), "retarget_hold");

      // ---------------- over-temperature ----------------------------------
      apply(0, 1, 5'd12, 0, 8'd20, 0, 0, '0, "");
      wait_power(5'd12, 80, "ot_reach12");
      f = ecnt;
      apply(0, 0, 5'd0, 0, 8'd251, 0, 1,
            OT_ON ? mk(0, 0, 1, 1) : mk(12, 0, 0, 0), "ot_trip");
      idle_chk(OT_ON ? mk(0, 0, 1, 1) : mk(12, 0, 0, 0), "ot_latched");
      apply(0, 0, 5'd0, 0, 8'd100, 1, 1,
            OT_ON ? mk(0, 0, 1, 0) : mk(12, 0, 0, 0), "ot_clear");
      while (ecnt + 1 < f + 10) idle(1);
      idle_chk(OT_ON ? mk(0, 0, 1, 0) : mk(12, 0, 0, 0), "ot_dead_done");
      wait_power(5'd12, 70, "ot_ramp_back");
      idle_chk(mk(12, 0, 0, 0), "ot_recovered_hold");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/chs_ramp_controller.md
# chs_ramp_controller

Sequential controller for the cooling/heating system (CHS). It takes the combinational power/mode request produced by the temperature-to-power mapper and drives the actual CHS actuator. Power is slew-limited to one step per tick, and a mode reversal always drains power to zero and waits a dead time before switching. It sits between the mapper output and the CHS actuator.

## Interface
Parameters:
- STEP_DIV, 4: clock cycles per power step (≥1)
- DEAD_CYCLES, 8: cycles held at zero power before a mode switch (≥1)
- OT_LIMIT, 8'd250: over-temperature threshold (used only with CHS_OVERTEMP_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  capture req_power/req_mode this edge
- req_power  in  5  requested power, 0..31
- req_mode  in  1  requested mode, same encoding as the mapper's chs_mode
- temp  in  8  current temperature code
- fault_clr  in  1  clear over-temperature fault
- chs_power  out  5  applied actuator power (registered)
- chs_mode  out  1  applied actuator mode (registered)
- busy  out  1  high whenever state ≠ HOLD
- ot_fault  out  1  over-temperature fault latched

## Operation
- Target registers tgt_power/tgt_mode load on any edge with req_valid=1. They reset to 0/0.
- States: HOLD, RAMP, DRAIN, DEAD, FAULT (FAULT exists only with the macro). Reset state is HOLD.
- HOLD:
  - tgt_mode≠chs_mode and chs_power>0 → DRAIN.
  - tgt_mode≠chs_mode and chs_power=0 → DEAD.
  - tgt_mode=chs_mode and chs_power≠tgt_power → RAMP.
- RAMP: on each tick, chs_power moves ±1 toward tgt_power. Direction is re-evaluated every tick against the current target. The step that reaches tgt_power also moves the state to HOLD. If tgt_mode becomes ≠chs_mode, the state moves to DRAIN on the next edge.
- DRAIN: on each tick, chs_power decrements by 1. The step reaching 0 moves the state to DEAD. Target power changes are ignored while in DRAIN.
- DEAD: chs_power holds at 0 for DEAD_CYCLES cycles, and the dead time always completes. At the final edge, chs_mode loads tgt_mode, and the state moves to RAMP if tgt_power>0, else to HOLD.
- Tick: a step counter runs 0..STEP_DIV-1 and is cleared on every state change. A step occurs on the edge where counter=STEP_DIV-1.
- Power never leaves 0..31. There is no wrap-around, because the target is bounded to 5 bits.
- Reset values: chs_power=0, chs_mode=0, busy=0, ot_fault=0. All counters are 0.

## Timing
- req_valid at edge 0 → tgt registered at edge 0 → state leaves HOLD at edge 1 → first power step at edge 1+STEP_DIV, then one step every STEP_DIV cycles.
- Entering DEAD at edge E → chs_mode updates at edge E+DEAD_CYCLES.
- rst=1 at any edge, in any state, forces reset values on that edge. rst has priority over all other inputs.
- A req_valid coinciding with a tick step: the step uses the old target, and the new target applies from the next tick.

## Configuration
- CHS_OVERTEMP_EN defined:
  - An edge with temp ≥ OT_LIMIT sets ot_fault, forces chs_power=0, and enters FAULT. This takes priority over every state except reset.
  - FAULT exits to DEAD on an edge with fault_clr=1 and temp < OT_LIMIT. ot_fault clears on that same edge.
  - Normal sequencing then resumes toward the current target.
- CHS_OVERTEMP_EN undefined: the FAULT state and comparator are absent, ot_fault is tied 0, and temp and fault_clr are ignored.

## Test plan
All scenarios use STEP_DIV=4 and DEAD_CYCLES=8.
- Reset: rst=1 for 2 cycles mid-RAMP → chs_power=0, chs_mode=0, busy=0, ot_fault=0 after the first rst edge.
- Ramp up: from 0/mode0, req 3/mode0 at edge 0 → chs_power 1, 2, 3 at edges 5, 9, 13; busy=0 from edge 13.
- Mode reversal: from 3/mode0, req 2/mode1 at edge 0 →
  - chs_power 2, 1, 0 at edges 5, 9, 13;
  - chs_mode=1 at edge 21;
  - chs_power 1, 2 at edges 25, 29;
  - HOLD from edge 29.
- Retarget mid-ramp: ramping toward 10, issue req 2/mode0 just after chs_power reaches 4 → chs_power steps 3, 2 on the following ticks, then HOLD.
- Zero-power mode change: 0/mode0, req 0/mode1 at edge 0 → DEAD at edge 1, chs_mode=1 at edge 9, chs_power stays 0, HOLD from edge 9.
- Over-temp (macro on): at chs_power=12, temp=8'd251 → chs_power=0 and ot_fault=1 next edge; fault_clr=1 with temp=8'd100 → ot_fault=0, then mode dead time completes and power ramps back to 12. With the macro off, the same stimulus leaves chs_power at 12.
